// File: rtl/unary_add_seq.sv
// Sequencer for a unary adder: streams operands as pulses, reads back ones.
// Ports: clk/rst_n, start/a_in/b_in in; busy/done/sum_out/ovf out; adder side A/B/en/read_or_write/adder_rst_n, dout/C.
module unary_add_seq #(
  parameter int W      = 4,
  parameter int RD_LEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic [W:0]   sum_out,
  output logic         ovf,
  output logic         adder_rst_n,
  output logic         A,
  output logic         B,
  output logic         en,
  output logic         read_or_write,
  input  logic         dout,
  input  logic         C
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_WR_HI = 3'd2;
  localparam logic [2:0] S_WR_LO = 3'd3;
  localparam logic [2:0] S_RD    = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int         CW       = $clog2(RD_LEN + 1);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_LEN - 1);
  localparam logic [W:0] ONES_MAX = '1;

  logic [2:0]    r_state;
  logic [W-1:0]  r_a_rem;
  logic [W-1:0]  r_b_rem;
  logic [W:0]    r_ones;
  logic          r_cflag;
  logic [CW-1:0] r_rd_cnt;
  logic [W:0]    r_sum;
  logic          r_ovf;
  logic          r_busy;
  logic          r_done;
  logic          r_a;
  logic          r_b;
  logic          r_en;
  logic          r_rw;

  logic [2:0]    w_nxt;
  logic [W:0]    w_ones_nxt;
  logic          w_cflag_nxt;
  logic          w_rem_nz;
  logic          w_rd_last;

  assign w_rem_nz  = (r_a_rem != '0) || (r_b_rem != '0);
  assign w_rd_last = (r_rd_cnt == RD_LAST);

  // Ones counter saturates instead of wrapping
  assign w_ones_nxt  = (dout && (r_ones != ONES_MAX))
                     ? r_ones + (W+1)'(1) : r_ones;
  assign w_cflag_nxt = r_cflag | C;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nxt = S_CLR;
      S_CLR:   w_nxt = w_rem_nz ? S_WR_HI : S_RD;
      S_WR_HI: w_nxt = S_WR_LO;
      S_WR_LO: w_nxt = w_rem_nz ? S_WR_HI : S_RD;
      S_RD:    if (w_rd_last) w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a_rem  <= '0;
      r_b_rem  <= '0;
      r_ones   <= '0;
      r_cflag  <= 1'b0;
      r_rd_cnt <= '0;
      r_sum    <= '0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_en     <= 1'b0;
      r_rw     <= 1'b0;
    end else begin
      r_state <= w_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_rem <= a_in;
            r_b_rem <= b_in;
            r_ones  <= '0;
            r_cflag <= 1'b0;
          end
        end
        S_WR_HI: begin
          if (r_a_rem != '0) r_a_rem <= r_a_rem - W'(1);
          if (r_b_rem != '0) r_b_rem <= r_b_rem - W'(1);
        end
        S_RD: begin
          r_ones   <= w_ones_nxt;
          r_cflag  <= w_cflag_nxt;
          r_rd_cnt <= r_rd_cnt + CW'(1);
          // Capture includes this final cycle's dout/C
          if (w_rd_last) begin
            r_sum <= w_ones_nxt;
            r_ovf <= w_cflag_nxt | (w_ones_nxt == ONES_MAX);
          end
        end
        default: ;
      endcase
      if ((w_nxt == S_RD) && (r_state != S_RD)) r_rd_cnt <= '0;
      // Outputs registered against the state being entered,
      // so they line up with r_state in the same cycle
      r_busy <= (w_nxt != S_IDLE);
      r_done <= (w_nxt == S_DONE);
      r_en   <= (w_nxt == S_WR_HI) || (w_nxt == S_WR_LO) ||
                (w_nxt == S_RD);
      r_rw   <= (w_nxt == S_RD);
      r_a    <= (w_nxt == S_WR_HI) && (r_a_rem != '0);
      r_b    <= (w_nxt == S_WR_HI) && (r_b_rem != '0);
    end
  end

  assign adder_rst_n   = rst_n & (r_state != S_CLR);
  assign busy          = r_busy;
  assign done          = r_done;
  assign sum_out       = r_sum;
  assign ovf           = r_ovf;
  assign A             = r_a;
  assign B             = r_b;
  assign en            = r_en;
  assign read_or_write = r_rw;

endmodule

// File: tb/tb_unary_add_seq.sv
// Bench for unary_add_seq with a behavioural unary adder.
// Scoreboard of expected sum/ovf, directed steps in one initial block.
module tb_unary_add_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic       busy;
  logic       done;
  logic [4:0] sum_out;
  logic       ovf;
  logic       adder_rst_n;
  logic       A;
  logic       B;
  logic       en;
  logic       read_or_write;
  logic       dout;
  logic       C;
  logic       force_ones = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0] sum;
    logic       ovf;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  unary_add_seq #(.W(4), .RD_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .sum_out(sum_out), .ovf(ovf), .adder_rst_n(adder_rst_n),
    .A(A), .B(B), .en(en), .read_or_write(read_or_write),
    .dout(dout), .C(C)
  );

  // Unary adder: accumulates pulses, then emits its count as ones
  int m_acc = 0;
  always @(posedge clk) begin
    if (adder_rst_n !== 1'b1) m_acc <= 0;
    else if (en === 1'b1 && read_or_write === 1'b0)
      m_acc <= m_acc + ((A === 1'b1) ? 1 : 0) + ((B === 1'b1) ? 1 : 0);
    else if (en === 1'b1 && read_or_write === 1'b1 && m_acc > 0)
      m_acc <= m_acc - 1;
  end
  assign dout = force_ones | (en & read_or_write & (m_acc != 0));
  assign C    = en & read_or_write & (m_acc == 16);

  // Pulse monitor
  int   a_cnt = 0;
  int   b_cnt = 0;
  int   consec = 0;
  logic pa = 1'b0;
  logic pb = 1'b0;
  always @(posedge clk) begin
    a_cnt  <= a_cnt + ((A === 1'b1) ? 1 : 0);
    b_cnt  <= b_cnt + ((B === 1'b1) ? 1 : 0);
    consec <= consec + ((((A === 1'b1) && pa) || ((B === 1'b1) && pb)) ? 1 : 0);
    pa <= (A === 1'b1);
    pb <= (B === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: unexpected done, sum %0h", tag, sum_out);
    end else begin
      e = sb.pop_front();
      chk({tag, "_sum"}, sum_out, e.sum);
      chk({tag, "_ovf"}, ovf, e.ovf);
    end
  endtask

  task automatic run_op(input string tag, input int a, input int b,
                        input bit frc, input int exp_lat);
    exp_t e;
    int   a0, b0, c0, lat;
    bit   got;
    e.sum = frc ? 5'd31 : 5'(a + b);
    e.ovf = frc || (a + b > 15);
    sb.push_back(e);
    @(negedge clk);
    a0 = a_cnt; b0 = b_cnt; c0 = consec;
    a_in = 4'(a); b_in = 4'(b); start = 1'b1; force_ones = frc;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_arst_lo"}, adder_rst_n, 0);
    got = 1'b0; lat = 0;
    for (int k = 1; k < 200 && !got; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) chk({tag, "_arst_hi"}, adder_rst_n, 1);
      if (done === 1'b1) begin got = 1'b1; lat = k; end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    if (got) sb_check(tag);
    else void'(sb.pop_front());
    chk({tag, "_apulse"}, a_cnt - a0, a);
    chk({tag, "_bpulse"}, b_cnt - b0, b);
    chk({tag, "_consec"}, consec - c0, 0);
    @(negedge clk);
    force_ones = 1'b0;
    chk({tag, "_done1"}, done, 0);
    chk({tag, "_hold"}, sum_out, e.sum);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int dcnt;
    int dt[3];
    exp_t e;
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ab", {A, B}, 0);
    chk("rst_en", {en, read_or_write}, 0);
    chk("rst_arst", adder_rst_n, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_arst", adder_rst_n, 1);

    run_op("a3b2", 3, 2, 1'b0, 39);
    run_op("a0b0", 0, 0, 1'b0, 33);
    run_op("a15b15", 15, 15, 1'b0, 63);
    run_op("a7b0", 7, 0, 1'b0, 47);
    run_op("sat", 0, 0, 1'b1, 33);

    // start held high: three accepts, each after an IDLE visit
    e.sum = 5'd2; e.ovf = 1'b0;
    repeat (3) sb.push_back(e);
    dcnt = 0; dt = '{0, 0, 0};
    a_in = 4'd1; b_in = 4'd1; start = 1'b1;
    for (int k = 0; k < 160; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 99) start = 1'b0;
      if (done === 1'b1) begin
        if (dcnt < 3) dt[dcnt] = k;
        dcnt++;
        sb_check("hold");
      end
    end
    chk("hold_cnt", dcnt, 3);
    chk("hold_t0", dt[0], 35);
    chk("hold_t1", dt[1], 72);
    chk("hold_t2", dt[2], 109);
    chk("hold_idle", busy, 0);

    // reset in the middle of RD discards the operation
    e.sum = 5'd10; e.ovf = 1'b0;
    sb.push_back(e);
    a_in = 4'd5; b_in = 4'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 100 && read_or_write !== 1'b1; k++) @(negedge clk);
    chk("mid_rd", read_or_write, 1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_sum", sum_out, 0);
    chk("mrst_ovf", ovf, 0);
    chk("mrst_ab", {A, B}, 0);
    chk("mrst_en", {en, read_or_write}, 0);
    chk("mrst_arst", adder_rst_n, 0);
    sb.delete();
    rst_n = 1'b1;
    dcnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    chk("mrst_nodone", dcnt, 0);
    chk("mrst_idle", busy, 0);
    run_op("after", 2, 1, 1'b0, 37);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
